// File: rtl/riscv_core_mdu_pkg.sv
// Shared definitions for the M-extension divide unit.
//   XLEN / WLEN  : datapath width and W-variant operand width
//   div_state_e  : divider FSM states
//   div_op_e     : op encodings, taken directly from funct3[1:0]
//   sext_w       : sign-extend a WLEN value to XLEN
package riscv_core_mdu_pkg;
  localparam int XLEN = 64;
  localparam int WLEN = 32;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} div_state_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v};
  endfunction
endpackage

// File: rtl/riscv_core_mdu_div_if.sv
// Request/response bundle between EX issue logic (master) and the divider
// (slave).
//   i_start/i_op/i_word/i_rs1/i_rs2 : request, held in EX while busy
//   i_flush                         : kill whatever is in flight
//   o_busy/o_done/o_result          : stall, one-cycle completion, result
//   o_divby0/o_of                   : special-case flags, valid with o_done
interface riscv_core_mdu_div_if;
  import riscv_core_mdu_pkg::*;

  logic            i_start;
  logic [1:0]      i_op;
  logic            i_word;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            i_flush;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;
  logic            o_divby0;
  logic            o_of;

  modport master (
    output i_start, i_op, i_word, i_rs1, i_rs2, i_flush,
    input  o_busy, o_done, o_result, o_divby0, o_of
  );

  modport slave (
    input  i_start, i_op, i_word, i_rs1, i_rs2, i_flush,
    output o_busy, o_done, o_result, o_divby0, o_of
  );
endinterface

// File: rtl/riscv_core_div_step.sv
// One restoring-division iteration (combinational).
//   rem     : partial remainder, always < dsr
//   din     : next dividend bit shifted in at the bottom
//   dsr     : divisor (magnitude)
//   rem_nxt : updated partial remainder
//   q_bit   : quotient bit produced by this step
module riscv_core_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem,
  input  logic         din,
  input  logic [W-1:0] dsr,
  output logic [W-1:0] rem_nxt,
  output logic         q_bit
);
  // rem < dsr, so the shifted value fits W+1 bits and a borrow shows up in
  // the top bit of the difference.
  logic [W:0] shifted, diff;

  always_comb begin
    shifted = {rem, din};
    diff    = shifted - {1'b0, dsr};
    q_bit   = ~diff[W];
    rem_nxt = q_bit ? diff[W-1:0] : shifted[W-1:0];
  end
endmodule

// File: rtl/riscv_core_mdu_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : request/response bundle, see riscv_core_mdu_div_if
// Timing: start accepted in cycle 0; divide-by-zero and signed overflow
// finish in cycle 1, everything else in cycle N+2 (N = XLEN or WLEN).
module riscv_core_mdu_div
  import riscv_core_mdu_pkg::*;
(
  input logic                 i_clk,
  input logic                 i_rst_n,
  riscv_core_mdu_div_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  div_state_e      state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem, dvd, dsr, result;
  logic            neg_q, neg_r, is_rem, is_word, dz_r, of_r;

  logic            accept, sgn, rem_op, s1, s2, dz, of, last, q_bit, done_q;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, min_neg, spec_res, raw, fix_res;
  logic [XLEN-1:0] rem_nxt;

  // Cycle-0 operand preparation and special-case detection.
  always_comb begin
    accept   = (state == S_IDLE) && bus.i_start && !bus.i_flush;
    sgn      = (bus.i_op == OP_DIV) || (bus.i_op == OP_REM);
    rem_op   = (bus.i_op == OP_REM) || (bus.i_op == OP_REMU);
    a_ext    = bus.i_rs1;
    b_ext    = bus.i_rs2;
    min_neg  = {1'b1, {(XLEN-1){1'b0}}};
    if (bus.i_word) begin
      a_ext   = sgn ? sext_w(bus.i_rs1[WLEN-1:0]) : XLEN'(bus.i_rs1[WLEN-1:0]);
      b_ext   = sgn ? sext_w(bus.i_rs2[WLEN-1:0]) : XLEN'(bus.i_rs2[WLEN-1:0]);
      min_neg = sext_w({1'b1, {(WLEN-1){1'b0}}});
    end
    s1       = sgn & a_ext[XLEN-1];
    s2       = sgn & b_ext[XLEN-1];
    abs_a    = s1 ? -a_ext : a_ext;
    abs_b    = s2 ? -b_ext : b_ext;
    dz       = (b_ext == '0);
    of       = sgn && (a_ext == min_neg) && (b_ext == '1);
    if (dz) spec_res = rem_op ? a_ext : '1;
    else    spec_res = rem_op ? '0 : a_ext;
    last     = cnt == (is_word ? CW'(WLEN-1) : CW'(XLEN-1));
  end

  // dvd doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  riscv_core_div_step #(.W(XLEN)) u_step (
    .rem     (rem),
    .din     (dvd[XLEN-1]),
    .dsr     (dsr),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  // Sign fix-up and select; W results are sign-extended from bit 31 even for
  // the unsigned forms.
  always_comb begin
    raw     = is_rem ? (neg_r ? -rem : rem) : (neg_q ? -dvd : dvd);
    fix_res = is_word ? sext_w(raw[WLEN-1:0]) : raw;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (dz || of) ? S_DONE : S_CALC;
      S_CALC: if (last) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.i_flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      rem     <= '0;
      dvd     <= '0;
      dsr     <= '0;
      result  <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      is_rem  <= 1'b0;
      is_word <= 1'b0;
      dz_r    <= 1'b0;
      of_r    <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      rem     <= '0;
      // W operands are left-aligned so the first WLEN steps consume them.
      dvd     <= bus.i_word ? {abs_a[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : abs_a;
      dsr     <= bus.i_word ? XLEN'(abs_b[WLEN-1:0]) : abs_b;
      neg_q   <= s1 ^ s2;
      neg_r   <= s1;
      is_rem  <= rem_op;
      is_word <= bus.i_word;
      dz_r    <= dz;
      of_r    <= of;
      if (dz || of) result <= bus.i_word ? sext_w(spec_res[WLEN-1:0]) : spec_res;
    end else if (state == S_CALC) begin
      rem <= rem_nxt;
      dvd <= {dvd[XLEN-2:0], q_bit};
      cnt <= cnt + 1'b1;
    end else if (state == S_FIX && !bus.i_flush) begin
      result <= fix_res;
    end
  end

  // A flush landing on the DONE cycle suppresses the completion as well.
  assign done_q       = (state == S_DONE) && !bus.i_flush;
  assign bus.o_busy   = (state != S_IDLE) || (bus.i_start && state == S_IDLE);
  assign bus.o_done   = done_q;
  assign bus.o_divby0 = done_q & dz_r;
  assign bus.o_of     = done_q & of_r;
  assign bus.o_result = result;
endmodule

// File: doc/riscv_core_mdu_div.md
Name: riscv_core_mdu_div

Overview:
- Iterative radix-2 restoring divider for RV64M: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- Sits in EX beside the ALU and feeds the hazard unit's M-extension request inputs: busy→mbusy, done→mdone, divby0→mdivby0, of→mof.
- Holds the issuing instruction in EX until the result is ready, then presents the result for one cycle.

Parameters:
- XLEN, 64, datapath width.
- WLEN, 32, operand width for W-variants.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  request; sampled only in IDLE.
- i_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- i_word  in  1  selects the W-variant.
- i_rs1  in  XLEN  dividend.
- i_rs2  in  XLEN  divisor.
- i_flush  in  1  kill the operation in flight (branch or CSR flush of EX).
- o_busy  out  1  unit occupied or request pending.
- o_done  out  1  one-cycle pulse; o_result is valid.
- o_result  out  XLEN  quotient or remainder.
- o_divby0  out  1  divisor was zero; valid with o_done.
- o_of  out  1  signed overflow; valid with o_done.

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst_n is asynchronous, active-low.
- Reset state: IDLE. All outputs 0. Internal registers cleared.
- Reset during an operation: the operation is aborted immediately and no done pulse is produced.
- States: IDLE, CALC, FIX, DONE.
- o_busy is combinational: (state != IDLE) || (i_start && state == IDLE). The hazard unit therefore stalls in the same cycle the request is issued.
- Cycle 0 is the cycle in which i_start is accepted in IDLE.
- Operand preparation in cycle 0:
  - W: take bits [31:0]; sign-extend for signed ops, zero-extend for unsigned ops.
  - Signed ops: take absolute values; record the quotient sign (s1^s2) and the remainder sign (s1).
- Special cases are detected in cycle 0 and go IDLE→DONE, so done is asserted in cycle 1:
  - Divide by zero (divisor == 0 after width selection): quotient = all ones; remainder = dividend (W: sign-extended rs1[31:0]); o_divby0=1.
  - Signed overflow (dividend most-negative, divisor -1, per width; signed ops only): quotient = dividend; remainder = 0; o_of=1.
- Normal path:
  - CALC for N cycles (N = XLEN, or WLEN when i_word), iteration counter 0..N-1. Each cycle performs one shift and trial subtract.
  - FIX for 1 cycle: apply signs and select quotient or remainder.
  - DONE in cycle N+2.
- W results: the 32-bit result is sign-extended to XLEN for all W ops, unsigned ones included.
- DONE:
  - o_done=1 for exactly one cycle; o_busy=1 during this cycle.
  - o_result, o_divby0 and o_of are valid only during this cycle.
  - Next state is IDLE.
  - i_start during DONE is ignored, because the same instruction is still in EX.
- o_divby0 and o_of are 0 outside DONE.
- o_result is held from DONE until the next accepted start.
- i_start outside IDLE is ignored.
- i_flush:
  - In any state, next state is IDLE; no done pulse; o_divby0 and o_of stay 0.
  - Flush wins over a simultaneous i_start in IDLE: the request is not accepted. o_busy may be 1 that cycle because it is combinational.
- Back-to-back requests: a new start is accepted in the first IDLE cycle after DONE.

Decomposition:
- Package riscv_core_mdu_pkg holds:
  - XLEN and WLEN.
  - State enum (IDLE, CALC, FIX, DONE).
  - Op encodings (DIV, DIVU, REM, REMU).
- Sub-module riscv_core_div_step: combinational single iteration. Inputs: partial remainder, dividend bit, divisor. Outputs: new remainder and quotient bit. Instantiated once.

Test Plan:
1. DIV rs1=-20, rs2=3 → o_result=0xFFFFFFFFFFFFFFFA in cycle 66; o_busy high cycles 0–66; o_done high only in cycle 66.
2. REM -20/3 → 0xFFFFFFFFFFFFFFFE; REMU 20/3 → 2; DIVUW rs1=0xFFFFFFFF, rs2=1 → 0xFFFFFFFFFFFFFFFF in cycle 34.
3. DIVW rs1=0x0000000080000000, rs2=0x00000000FFFFFFFF → cycle 1: o_done=1, o_of=1, o_divby0=0, o_result=0xFFFFFFFF80000000. REMW with the same operands → 0.
4. DIVU 5/0 → cycle 1: o_result=all ones, o_divby0=1. REMU 5/0 → 5. REMW rs1=0x80000000, rs2=0 → 0xFFFFFFFF80000000.
5. i_flush in cycle 10 of a DIV → IDLE in cycle 11, o_busy=0, no o_done. i_start in cycle 12 is accepted; the result appears in cycle 78.
6. i_rst_n low in cycle 20 of CALC → all outputs 0 immediately and no o_done afterwards. Separately, i_start held high through DONE → exactly one operation completes; the next operation starts in the following IDLE cycle.
